jtvigil_scr2_fetch: RTL and testbench

Line-prefetch controller for the Vigilante scroll-2 (background) layer. On every line start it sequences 33 consecutive 32-bit graphics ROM reads for the *next* line, over the SDRAM `rom_cs/rom_ok` handshake. It writes them into one bank of an external ping-pong line buffer, so the pixel shifter reads from local RAM instead of hitting the ROM every 8 pixels. It sits between the scroll-2 pixel path and the SDRAM ROM port.

---
 rtl/jtvigil_pkg.sv | 32 +++
 rtl/jtvigil_scr2_addr.sv | 22 ++
 rtl/jtvigil_scr2_fetch.sv | 189 ++++++++++++++++++
 tb/tb_jtvigil_scr2_fetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_pkg.sv
// Shared definitions for the Vigilante scroll-2 line prefetch logic.
// Holds the fetch FSM state type, the per-line word count, the fixed
// horizontal scroll offset and the ROM-to-line-buffer half-swap helper.
package jtvigil_pkg;

  // Words fetched per line: 256 px / 8 px per word, plus one for fine scroll.
  localparam int SCR2_WORDS = 33;

  // Constant added to the scroll register before splitting it into
  // coarse column and fine pixel offset.
  localparam logic [10:0] SCR2_SCROLL_OFS = 11'h080;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } scr2_state_t;

  // ROM words carry two 16-bit halves. With flip clear the halves are
  // exchanged so the shifter always consumes the buffer in the same order.
  function automatic logic [31:0] scr2_swap(input logic [31:0] data, input logic flip);
    logic [31:0] res;
    if (!flip) begin
      res = {data[15:0], data[31:16]};
    end else begin
      res = data;
    end
    return res;
  endfunction

endpackage

// File: rtl/jtvigil_scr2_addr.sv
// Scroll-2 ROM address generator (combinational).
// Word k of a line lives at column c = col0 + k, wrapping on the 256-column
// (2048 px) ring. The low address bit selects the half-word order for flip.
module jtvigil_scr2_addr
  import jtvigil_pkg::*;
(
  input  logic [7:0]  col0,
  input  logic [5:0]  k,
  input  logic [7:0]  vn,
  input  logic        flip,
  output logic [17:0] addr
);

  logic [7:0] col;

  // Column of the requested word and its packed ROM address.
  always_comb begin
    col  = col0 + {2'b00, k};
    addr = {1'b0, col[7:6], vn, col[5:0], ~flip};
  end

endmodule

// File: rtl/jtvigil_scr2_fetch.sv
// Vigilante scroll-2 line prefetch controller.
// On every rising edge of hs it reads 33 ROM words for the next line and
// writes them into the bank of the external ping-pong line buffer that the
// pixel shifter is not reading. A new line start while a fetch is still
// running aborts it (miss pulse) and restarts for the new line.
// Optional build macro: JTVIGIL_SCR2_MISSCNT_EN adds a saturating abort
// counter on debug_view; without it debug_view is tied to zero.
module jtvigil_scr2_fetch
  import jtvigil_pkg::*;
#(
  parameter int WORDS = SCR2_WORDS
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        hs,
  input  logic [8:0]  v,
  input  logic        flip,
  input  logic [10:0] scrpos,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic        buf_we,
  output logic [6:0]  buf_addr,
  output logic [31:0] buf_din,
  output logic [2:0]  fine_x,
  output logic        busy,
  output logic        miss,
  output logic [7:0]  debug_view
);

  localparam logic [5:0] LAST_K = 6'(WORDS - 1);

  scr2_state_t state;

  logic        hs_d;
  logic        line_start;
  logic [10:0] scr_ofs;

  // Fields latched at line start for the line being fetched.
  logic [7:0]  vn;
  logic [7:0]  col0;
  logic        bank;
  logic [2:0]  fx;
  logic [5:0]  k;

  // Low during the first REQ cycle of each address: rom_ok is still stale.
  logic        ok_arm;

  // Inputs to the address generator for the next address to be presented.
  logic [7:0]  a_col0;
  logic [7:0]  a_vn;
  logic [5:0]  a_k;
  logic [17:0] addr_nxt;

  // Only the low 8 bits of the line counter select ROM rows.
  logic        unused_v8;
  assign unused_v8 = v[8];

  assign line_start = hs & ~hs_d;
  assign scr_ofs    = scrpos + SCR2_SCROLL_OFS;

  // Select the next address source: fresh line fields on line start,
  // otherwise the following word of the current line.
  always_comb begin
    a_col0 = col0;
    a_vn   = vn;
    a_k    = k + 6'd1;
    if (line_start) begin
      a_col0 = scr_ofs[10:3];
      a_vn   = v[7:0] + 8'd1;
      a_k    = 6'd0;
    end else begin
      a_col0 = col0;
      a_vn   = vn;
      a_k    = k + 6'd1;
    end
  end

  jtvigil_scr2_addr u_addr (
    .col0 (a_col0),
    .k    (a_k),
    .vn   (a_vn),
    .flip (flip),
    .addr (addr_nxt)
  );

  // Fetch sequencer: line-start detection, ROM handshake, buffer writes and
  // abort handling, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hs_d     <= 1'b0;
      vn       <= 8'h00;
      col0     <= 8'h00;
      bank     <= 1'b0;
      fx       <= 3'd0;
      k        <= 6'd0;
      ok_arm   <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= 18'h0_0000;
      buf_we   <= 1'b0;
      buf_addr <= 7'h00;
      buf_din  <= 32'h0000_0000;
      fine_x   <= 3'd0;
      busy     <= 1'b0;
      miss     <= 1'b0;
    end else begin
      hs_d   <= hs;
      miss   <= 1'b0;
      buf_we <= 1'b0;
      if (line_start) begin
        // A line start always wins: abort anything in flight and restart.
        miss     <= (state != ST_IDLE);
        vn       <= a_vn;
        bank     <= a_vn[0];
        col0     <= a_col0;
        fx       <= scr_ofs[2:0];
        k        <= 6'd0;
        ok_arm   <= 1'b0;
        rom_cs   <= 1'b1;
        rom_addr <= addr_nxt;
        busy     <= 1'b1;
        state    <= ST_REQ;
      end else begin
        case (state)
          ST_IDLE: begin
            rom_cs <= 1'b0;
            busy   <= 1'b0;
          end
          ST_REQ: begin
            if (!ok_arm) begin
              ok_arm <= 1'b1;
            end else if (rom_ok) begin
              rom_cs   <= 1'b0;
              buf_we   <= 1'b1;
              buf_addr <= {bank, k};
              buf_din  <= scr2_swap(rom_data, flip);
              state    <= ST_WR;
            end else begin
              ok_arm <= 1'b1;
            end
          end
          ST_WR: begin
            if (k == LAST_K) begin
              state <= ST_DONE;
            end else begin
              k        <= a_k;
              ok_arm   <= 1'b0;
              rom_cs   <= 1'b1;
              rom_addr <= addr_nxt;
              state    <= ST_REQ;
            end
          end
          ST_DONE: begin
            fine_x <= fx;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
          default: begin
            rom_cs <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef JTVIGIL_SCR2_MISSCNT_EN
  logic [7:0] miss_cnt;

  // Saturating count of aborted fetches for debugging bandwidth problems.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= 8'h00;
    end else if (miss && (miss_cnt != 8'hFF)) begin
      miss_cnt <= miss_cnt + 8'd1;
    end else begin
      miss_cnt <= miss_cnt;
    end
  end

  assign debug_view = miss_cnt;
`else
  assign debug_view = 8'h00;
`endif

endmodule

// File: tb/tb_jtvigil_scr2_fetch.sv
// Directed self-checking bench for jtvigil_scr2_fetch.
// Outputs are sampled on the falling clock edge; ROM handshake, write and
// request logs are captured by the tick task in the same thread.
module tb_jtvigil_scr2_fetch;

  logic        rst;
  logic        clk;
  logic        hs;
  logic [8:0]  v;
  logic        flip;
  logic [10:0] scrpos;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic        rom_ok;
  logic [31:0] rom_data;
  logic        buf_we;
  logic [6:0]  buf_addr;
  logic [31:0] buf_din;
  logic [2:0]  fine_x;
  logic        busy;
  logic        miss;
  logic [7:0]  debug_view;

  int checks = 0;
  int errors = 0;

  // Bench-side ROM behaviour and logs.
  logic        auto_ok;
  logic        use_fixed;
  logic [31:0] fixed_data;
  logic        prev_cs;
  logic [17:0] prev_addr;
  int          wr_cnt;
  int          rq_cnt;
  int          miss_seen;
  logic [6:0]  wr_addr [64];
  logic [31:0] wr_din  [64];
  logic [17:0] rq_addr [64];

  jtvigil_scr2_fetch dut (
    .rst        (rst),
    .clk        (clk),
    .hs         (hs),
    .v          (v),
    .flip       (flip),
    .scrpos     (scrpos),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_ok     (rom_ok),
    .rom_data   (rom_data),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_din    (buf_din),
    .fine_x     (fine_x),
    .busy       (busy),
    .miss       (miss),
    .debug_view (debug_view)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, log DUT activity, then drive the ROM.
  task automatic tick();
    @(negedge clk);
    if (buf_we && wr_cnt < 64) begin
      wr_addr[wr_cnt] = buf_addr;
      wr_din[wr_cnt]  = buf_din;
      wr_cnt++;
    end
    if (rom_cs && (!prev_cs || rom_addr != prev_addr) && rq_cnt < 64) begin
      rq_addr[rq_cnt] = rom_addr;
      rq_cnt++;
    end
    prev_cs   = rom_cs;
    prev_addr = rom_addr;
    if (miss) miss_seen++;
    if (auto_ok) rom_ok = rom_cs;
    rom_data = use_fixed ? fixed_data : {14'h0000, rom_addr};
  endtask

  task automatic clear_log();
    wr_cnt    = 0;
    rq_cnt    = 0;
    miss_seen = 0;
  endtask

  // One hs pulse; returns at the falling edge after the start was registered.
  task automatic start_line(input logic [8:0] vv, input logic [10:0] sp, input logic fl);
    v      = vv;
    scrpos = sp;
    flip   = fl;
    hs     = 1'b1;
    tick();
    hs     = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; hs = 1'b0; v = 9'd0; flip = 1'b0; scrpos = 11'h000;
    rom_ok = 1'b0; rom_data = 32'h0000_0000;
    auto_ok = 1'b1; use_fixed = 1'b0; fixed_data = 32'h0000_0000;
    prev_cs = 1'b0; prev_addr = 18'h0_0000;
    clear_log();

    // Reset state.
    #3;
    chk("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("rst_rom_addr", {14'd0, rom_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_buf_we", {31'd0, buf_we}, 32'd0);
    chk("rst_fine_x", {29'd0, fine_x}, 32'd0);
    chk("rst_miss", {31'd0, miss}, 32'd0);
    chk("rst_debug", {24'd0, debug_view}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Address sequence: scrpos 0, v 9 -> vn 0x0A, col0 0x10, bank 0.
    clear_log();
    start_line(9'd9, 11'h000, 1'b0);
    chk("t1_cs_rise", {31'd0, rom_cs}, 32'd1);
    chk("t1_busy_rise", {31'd0, busy}, 32'd1);
    chk("t1_addr0", {14'd0, rom_addr}, 32'h0000_0521);
    wait_idle(n);
    // 33 words x 3 clocks from rom_cs rising, then one DONE cycle.
    chk("t1_cycles", n, 32'd100);
    chk("t1_wr_cnt", wr_cnt, 32'd33);
    chk("t1_rq_cnt", rq_cnt, 32'd33);
    for (int i = 0; i < 33; i++) begin
      chk($sformatf("t1_wr_addr%0d", i), {25'd0, wr_addr[i]}, {25'd0, 1'b0, 6'(i)});
    end
    chk("t1_rq0", {14'd0, rq_addr[0]}, 32'h0000_0521);
    chk("t1_rq32", {14'd0, rq_addr[32]}, 32'h0000_0561);
    chk("t1_din0", wr_din[0], 32'h0521_0000);
    chk("t1_fine_x", {29'd0, fine_x}, 32'd0);

    // Column wrap: 0x780 + 0x080 wraps to 0, so col0 = 0x00.
    clear_log();
    start_line(9'd9, 11'h780, 1'b0);
    wait_idle(n);
    chk("t2_rq0", {14'd0, rq_addr[0]}, 32'h0000_0501);
    chk("t2_rq32", {14'd0, rq_addr[32]}, 32'h0000_0541);
    chk("t2_fine_x", {29'd0, fine_x}, 32'd0);

    // Ring wrap inside a line plus vn wrap: col0 0xF0, v 0x1FF -> vn 0x00.
    clear_log();
    start_line(9'h1FF, 11'h700, 1'b0);
    wait_idle(n);
    chk("t2b_rq0", {14'd0, rq_addr[0]}, 32'h0001_8061);
    chk("t2b_rq16", {14'd0, rq_addr[16]}, 32'h0000_0001);
    chk("t2b_rq32", {14'd0, rq_addr[32]}, 32'h0000_0021);

    // Fine scroll with flip: scrpos 5 -> fx 5, v 10 -> vn 0x0B, bank 1.
    clear_log();
    use_fixed = 1'b1; fixed_data = 32'h1234_5678;
    start_line(9'd10, 11'h005, 1'b1);
    wait_idle(n);
    chk("t3_fine_x", {29'd0, fine_x}, 32'd5);
    chk("t3_din", wr_din[0], 32'h1234_5678);
    chk("t3_addr_lsb", {31'd0, rq_addr[0][0]}, 32'd0);
    chk("t3_rq0", {14'd0, rq_addr[0]}, 32'h0000_05A0);
    chk("t3_wr_addr0", {25'd0, wr_addr[0]}, 32'h0000_0040);

    // Half swap with flip clear; scrpos 2 leaves fine_x = 2 for later.
    clear_log();
    start_line(9'd10, 11'h002, 1'b0);
    wait_idle(n);
    chk("t4_din", wr_din[0], 32'h5678_1234);
    chk("t4_fine_x", {29'd0, fine_x}, 32'd2);
    use_fixed = 1'b0;

    // Stale rom_ok: high only in the first cycle after the address appears.
    clear_log();
    auto_ok = 1'b0; rom_ok = 1'b0;
    start_line(9'd20, 11'h003, 1'b0);
    rom_ok = 1'b1;
    tick();
    rom_ok = 1'b0;
    tick();
    tick();
    chk("t5_stale_ignored", wr_cnt, 32'd0);
    chk("t5_cs_held", {31'd0, rom_cs}, 32'd1);
    rom_ok = 1'b1;
    tick();
    chk("t5_late_accept", {31'd0, buf_we}, 32'd1);
    rom_ok = 1'b0;

    // Slow ROM and abort at word 10.
    auto_ok = 1'b1;
    n = 0;
    while (wr_cnt < 10 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_reach_w10", wr_cnt, 32'd10);
    auto_ok = 1'b0; rom_ok = 1'b0;
    tick();
    tick();
    chk("t5_addr_w10", {14'd0, rom_addr}, 32'h0000_0AB5);
    miss_seen = 0;
    start_line(9'd21, 11'h003, 1'b0);
    chk("t5_miss", {31'd0, miss}, 32'd1);
    chk("t5_restart_addr", {14'd0, rom_addr}, 32'h0000_0B21);
    chk("t5_restart_cs", {31'd0, rom_cs}, 32'd1);
    chk("t5_fine_x_kept", {29'd0, fine_x}, 32'd2);
    tick();
    chk("t5_miss_drop", {31'd0, miss}, 32'd0);
    chk("t5_no_write", wr_cnt, 32'd10);
`ifdef JTVIGIL_SCR2_MISSCNT_EN
    chk("t5_debug_one", {24'd0, debug_view}, 32'd1);
`else
    chk("t5_debug_zero", {24'd0, debug_view}, 32'd0);
`endif
    auto_ok = 1'b1;
    wait_idle(n);
    chk("t5_miss_once", miss_seen, 32'd1);
    chk("t5_fine_x_new", {29'd0, fine_x}, 32'd3);
    chk("t5_wr_addr10", {25'd0, wr_addr[10]}, 32'h0000_0000);
    chk("t5_wr_din10", wr_din[10], 32'h0B21_0000);

    // Asynchronous reset in the middle of a fetch.
    start_line(9'd30, 11'h000, 1'b1);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cs", {31'd0, rom_cs}, 32'd0);
    chk("t6_rst_addr", {14'd0, rom_addr}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_fine_x", {29'd0, fine_x}, 32'd0);
    chk("t6_rst_buf_we", {31'd0, buf_we}, 32'd0);
    chk("t6_rst_debug", {24'd0, debug_view}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 300 back-to-back aborts (the first start comes from IDLE).
    for (int i = 0; i < 301; i++) begin
      hs = 1'b1;
      tick();
      hs = 1'b0;
      tick();
    end
    tick();
`ifdef JTVIGIL_SCR2_MISSCNT_EN
    chk("t7_debug_sat", {24'd0, debug_view}, 32'h0000_00FF);
`else
    chk("t7_debug_off", {24'd0, debug_view}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
